// File: rtl/adder_pkg.sv
// Shared operation encoding, default parameters and the checker-side reference model.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SADD = 2'd2,
    OP_SSUB = 2'd3
  } op_e;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 2;
  localparam int unsigned DEF_TAG_W  = 4;

  // Widest operand the reference model handles.
  localparam int unsigned MODEL_MAX_W = 32;

  typedef struct packed {
    logic                   carry;
    logic [MODEL_MAX_W-1:0] sum;
  } model_res_t;

  // Reference result for one operation at a given operand width (width <= MODEL_MAX_W).
  function automatic model_res_t adder_model(input op_e                    op,
                                             input logic [MODEL_MAX_W-1:0] a,
                                             input logic [MODEL_MAX_W-1:0] b,
                                             input logic                   cin,
                                             input int unsigned            width);
    longint unsigned lim;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uc;
    longint unsigned r;
    logic            ovf;
    logic            unf;
    model_res_t      res;
    lim = (64'd1 << width) - 64'd1;
    ua  = 64'(a) & lim;
    ub  = 64'(b) & lim;
    uc  = 64'(cin);
    res = '0;
    r   = ua + ub + uc;
    ovf = (r > lim);
    unf = (ua < (ub + uc));
    case (op)
      OP_ADD: begin
        res.sum   = MODEL_MAX_W'(r & lim);
        res.carry = ovf;
      end
      OP_SADD: begin
        res.sum   = ovf ? MODEL_MAX_W'(lim) : MODEL_MAX_W'(r);
        res.carry = ovf;
      end
      OP_SUB: begin
        res.sum   = MODEL_MAX_W'((ua - ub - uc) & lim);
        res.carry = unf;
      end
      default: begin
        res.sum   = unf ? '0 : MODEL_MAX_W'(ua - ub - uc);
        res.carry = unf;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adder_alu.sv
// Combinational add/subtract core with optional saturation.
module adder_alu
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int unsigned RW = WIDTH + 1;

  logic [RW-1:0] r_add_c;
  logic [RW-1:0] r_sub_c;

  // Extended-width sum and difference; the top bit is carry-out or borrow-out.
  always_comb begin
    r_add_c = {1'b0, A} + {1'b0, B} + RW'(cin);
    r_sub_c = {1'b0, A} - {1'b0, B} - RW'(cin);
  end

  // Select the result for the requested operation, clamping in saturating modes.
  always_comb begin
    sum   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = r_add_c[WIDTH-1:0];
        carry = r_add_c[WIDTH];
      end
      OP_SUB: begin
        sum   = r_sub_c[WIDTH-1:0];
        carry = r_sub_c[WIDTH];
      end
      OP_SADD: begin
        sum   = r_add_c[WIDTH] ? '1 : r_add_c[WIDTH-1:0];
        carry = r_add_c[WIDTH];
      end
      OP_SSUB: begin
        sum   = r_sub_c[WIDTH] ? '0 : r_sub_c[WIDTH-1:0];
        carry = r_sub_c[WIDTH];
      end
      default: begin
        sum   = r_add_c[WIDTH-1:0];
        carry = r_add_c[WIDTH];
      end
    endcase
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder with valid/ready handshake, full backpressure and tag pass-through.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [TAG_W-1:0] out_tag
);

  logic             adv_c;
  logic [WIDTH-1:0] alu_sum_c;
  logic             alu_carry_c;

  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];
  logic [TAG_W-1:0] tag_d   [STAGES];

  adder_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .sum   (alu_sum_c),
    .carry (alu_carry_c)
  );

  // Whole pipeline moves unless the output beat is stuck waiting for the consumer.
  always_comb begin
    adv_c    = out_ready | ~out_valid;
    in_ready = adv_c;
  end

  // Next-state: stage 0 captures the ALU result, later stages copy their predecessor.
  // Payload registers only load on a valid beat so bubbles leave the last result visible.
  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    tag_d   = tag_q;
    if (adv_c) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        sum_d[0]   = alu_sum_c;
        carry_d[0] = alu_carry_c;
        tag_d[0]   = in_tag;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          sum_d[i]   = sum_q[i-1];
          carry_d[i] = carry_q[i-1];
          tag_d[i]   = tag_q[i-1];
        end
      end
    end
  end

  // Stage registers; reset flushes every in-flight beat and clears the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: 1'b0};
      sum_q   <= '{default: '0};
      carry_q <= '{default: 1'b0};
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign carry     = carry_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded checks of pipelined_adder at STAGES = 2, 1 and 4.
module tb_pipelined_adder;
  import adder_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  op_e           op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          cin;
  logic [TW-1:0] in_tag;

  logic rdy2, ov2, c2; logic [W-1:0] s2; logic [TW-1:0] t2;
  logic rdy1, ov1, c1; logic [W-1:0] s1; logic [TW-1:0] t1;
  logic rdy4, ov4, c4; logic [W-1:0] s4; logic [TW-1:0] t4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .op(op), .A(A), .B(B),
    .cin(cin), .in_tag(in_tag), .out_valid(ov2), .out_ready(out_ready), .sum(s2),
    .carry(c2), .out_tag(t2));

  pipelined_adder #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .op(op), .A(A), .B(B),
    .cin(cin), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready), .sum(s1),
    .carry(c1), .out_tag(t1));

  pipelined_adder #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .op(op), .A(A), .B(B),
    .cin(cin), .in_tag(in_tag), .out_valid(ov4), .out_ready(out_ready), .sum(s4),
    .carry(c4), .out_tag(t4));

  typedef struct packed {
    op_e          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          carry;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   acc4 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_exp();
    model_res_t r;
    exp_t       e;
    r       = adder_model(op, 32'(A), 32'(B), cin, W);
    e.sum   = W'(r.sum);
    e.carry = r.carry;
    e.tag   = in_tag;
    return e;
  endfunction

  // Called with inputs settled, before the clock edge: score emitted beats, queue accepted ones.
  task automatic sb_step();
    exp_t e;
    if (ov1 && out_ready) begin
      if (q1.size() == 0) chk("s1_extra_beat", 32'(ov1), 32'(0));
      else begin
        e = q1.pop_front();
        chk("s1_sum", 32'(s1), 32'(e.sum));
        chk("s1_carry", 32'(c1), 32'(e.carry));
        chk("s1_tag", 32'(t1), 32'(e.tag));
      end
    end
    if (ov4 && out_ready) begin
      if (q4.size() == 0) chk("s4_extra_beat", 32'(ov4), 32'(0));
      else begin
        e = q4.pop_front();
        chk("s4_sum", 32'(s4), 32'(e.sum));
        chk("s4_carry", 32'(c4), 32'(e.carry));
        chk("s4_tag", 32'(t4), 32'(e.tag));
      end
    end
    if (in_valid && rdy1) q1.push_back(model_exp());
    if (in_valid && rdy4) begin
      q4.push_back(model_exp());
      acc4++;
    end
  endtask

  task automatic drive_bp(input int k);
    if (k < 5) begin
      in_valid = 1'b1;
      op       = OP_ADD;
      A        = W'(10 * k);
      B        = W'(k);
      cin      = 1'b1;
      in_tag   = TW'(k);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  vec_t          vecs [12];
  logic [TW-1:0] got_tag [5];
  logic [W-1:0]  got_sum [5];

  initial begin
    int k;
    int n;
    int cyc;

    vecs = '{
      '{OP_ADD,  8'd200, 8'd100, 1'b0, 8'd44,  1'b1},
      '{OP_ADD,  8'd1,   8'd2,   1'b1, 8'd4,   1'b0},
      '{OP_SUB,  8'd5,   8'd7,   1'b0, 8'd254, 1'b1},
      '{OP_SUB,  8'd7,   8'd5,   1'b1, 8'd1,   1'b0},
      '{OP_SADD, 8'd200, 8'd100, 1'b0, 8'd255, 1'b1},
      '{OP_SSUB, 8'd5,   8'd7,   1'b0, 8'd0,   1'b1},
      '{OP_SADD, 8'd255, 8'd0,   1'b1, 8'd255, 1'b1},
      '{OP_SADD, 8'd254, 8'd0,   1'b1, 8'd255, 1'b0},
      '{OP_SSUB, 8'd0,   8'd0,   1'b1, 8'd0,   1'b1},
      '{OP_SSUB, 8'd5,   8'd5,   1'b0, 8'd0,   1'b0},
      '{OP_SUB,  8'd0,   8'd255, 1'b1, 8'd0,   1'b1},
      '{OP_SADD, 8'd10,  8'd20,  1'b0, 8'd30,  1'b0}
    };

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
    A = '0; B = '0; cin = 1'b0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov2), 32'(0));
    chk("rst_sum", 32'(s2), 32'(0));
    chk("rst_carry", 32'(c2), 32'(0));
    chk("rst_out_tag", 32'(t2), 32'(0));
    chk("rst_in_ready", 32'(rdy2), 32'(1));
    chk("rst_in_ready_s1", 32'(rdy1), 32'(1));

    // Directed vectors, one at a time, STAGES = 2 latency
    for (int i = 0; i < 12; i++) begin
      op = vecs[i].op; A = vecs[i].a; B = vecs[i].b; cin = vecs[i].cin;
      in_tag = TW'(i + 3); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (i == 0) chk("lat_not_early", 32'(ov2), 32'(0));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 32'(ov2), 32'(1));
      chk($sformatf("vec%0d_sum", i), 32'(s2), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_carry", i), 32'(c2), 32'(vecs[i].carry));
      chk($sformatf("vec%0d_tag", i), 32'(t2), 32'(i + 3));
    end
    @(posedge clk); #1;
    chk("idle_valid", 32'(ov2), 32'(0));
    chk("idle_sum_hold", 32'(s2), 32'(30));
    chk("idle_tag_hold", 32'(t2), 32'(14));

    // Backpressure: stalled output, tags 0..4 offered back-to-back
    out_ready = 1'b0;
    k = 0;
    repeat (6) begin
      drive_bp(k);
      #1;
      if (ov2) begin
        chk("bp_hold_tag", 32'(t2), 32'(0));
        chk("bp_hold_sum", 32'(s2), 32'(1));
      end
      if (in_valid && rdy2) k++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(k), 32'(2));
    chk("bp_in_ready_low", 32'(rdy2), 32'(0));
    out_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 40) begin
      drive_bp(k);
      #1;
      if (ov2) begin
        if (n < 5) begin
          got_tag[n] = t2;
          got_sum[n] = s2;
        end
        n++;
      end
      if (in_valid && rdy2) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(n), 32'(5));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_tag%0d", i), 32'(got_tag[i]), 32'(i));
      chk($sformatf("bp_sum%0d", i), 32'(got_sum[i]), 32'(11 * i + 1));
    end
    #1 chk("bp_no_dup", 32'(ov2), 32'(0));

    // Reset with two beats in flight
    out_ready = 1'b0;
    op = OP_ADD; A = 8'd1; B = 8'd1; cin = 1'b0; in_tag = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mr_inflight", 32'(ov2), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_valid", 32'(ov2), 32'(0));
    chk("mr_sum", 32'(s2), 32'(0));
    chk("mr_tag", 32'(t2), 32'(0));
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("mr_no_out", 32'(ov2), 32'(0));
    end

    // Random stream against the package model, STAGES = 1 and 4
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    while (acc4 < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      op        = op_e'(2'($urandom_range(0, 3)));
      A         = W'($urandom);
      B         = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      in_tag    = TW'(cyc);
      #1;
      sb_step();
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_beats", 32'(acc4 >= 1000), 32'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      #1;
      sb_step();
      @(posedge clk); #1;
    end
    chk("rand_s1_drained", 32'(q1.size()), 32'(0));
    chk("rand_s4_drained", 32'(q4.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the 8-bit registered adder. It adds WIDTH bits in place of 8 and supports four arithmetic modes: add, subtract, saturating add and saturating subtract. It has a carry/borrow input and a configurable pipeline depth. A valid/ready handshake with full backpressure lets it sit between a stimulus source and a checker in the block-level testbench top. A tag travels alongside each operation so the checker can confirm ordering.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
STAGES, 2, pipeline depth in register stages (>=1); equals latency with no stall
TAG_W, 4, width of the pass-through transaction tag (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
op  in  2  operation, one of the shared op enum values
A  in  WIDTH  operand A, unsigned
B  in  WIDTH  operand B, unsigned
cin  in  1  carry-in (ADD/SADD) or borrow-in (SUB/SSUB)
in_tag  in  TAG_W  transaction tag
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
carry  out  1  carry-out / borrow-out / saturation flag
out_tag  out  TAG_W  tag of the result beat

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: every stage valid bit = 0, out_valid = 0, sum = 0, carry = 0, out_tag = 0. in_ready = 1 in the first cycle after reset is released.
- Advance enable: adv = out_ready | ~out_valid. All stages shift together when adv = 1 and hold when adv = 0.
- in_ready = adv, combinational. A beat is accepted when in_valid & in_ready.
- Bubbles are kept in place; they are not collapsed. An empty stage is simply shifted through.
- Stage 1 registers the complete result. Stages 2..STAGES delay {valid, sum, carry, tag} unchanged.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles later if there is no stall.
- Throughput: one beat per cycle while out_ready = 1.
- Output payload holds while out_valid = 1 and out_ready = 0. The transfer completes on out_valid & out_ready.
- Arithmetic uses a WIDTH+1 internal result r:
- OP_ADD: r = A + B + cin; sum = r[WIDTH-1:0]; carry = r[WIDTH].
- OP_SUB: r = A - B - cin; sum = r[WIDTH-1:0]; carry = 1 iff A < B + cin (borrow).
- OP_SADD: same as ADD, but on overflow sum = all ones and carry = 1; otherwise carry = 0.
- OP_SSUB: same as SUB, but on underflow sum = 0 and carry = 1; otherwise carry = 0.
- Payload of a bubble stage: don't-care internally, but sum/carry/out_tag hold their last values when out_valid = 0. No X is allowed on the outputs.
- Reset mid-operation: all in-flight beats are discarded and the outputs return to their reset values on the next edge. Nothing that was in flight emerges after reset.
- Simultaneous accept and output: allowed every cycle. A pipeline that is full and not stalled accepts and emits in the same cycle.
- STAGES = 1: a single register stage. The same handshake rules apply.

Decomposition:
- Package adder_pkg holds:
- typedef enum logic [1:0] op_e {OP_ADD = 0, OP_SUB = 1, OP_SADD = 2, OP_SSUB = 3}
- the default WIDTH/STAGES/TAG_W constants
- Sub-module adder_alu: purely combinational. Inputs are op, A, B and cin; outputs are sum and carry with the saturation logic.
- The top module holds the pipeline registers and the handshake.
- Checker-side reference model: a function in adder_pkg reusing op_e.

Test Plan:
- Reset -> out_valid = 0, sum = 0, carry = 0 and in_ready = 1 after rst is released. Asserting rst again with 2 beats in flight -> no out_valid afterwards.
- WIDTH = 8, STAGES = 2, OP_ADD, A = 200, B = 100, cin = 0, tag = 3 -> two cycles later sum = 44, carry = 1, out_tag = 3. With A = 1, B = 2, cin = 1 -> sum = 4, carry = 0.
- OP_SUB, A = 5, B = 7, cin = 0 -> sum = 254, carry = 1. With A = 7, B = 5, cin = 1 -> sum = 1, carry = 0.
- OP_SADD, A = 200, B = 100 -> sum = 255, carry = 1. OP_SSUB, A = 5, B = 7 -> sum = 0, carry = 1. OP_SADD, A = 10, B = 20 -> sum = 30, carry = 0.
- Backpressure: hold out_ready = 0 while sending tags 0..4 back-to-back -> in_ready drops after STAGES beats are accepted. Then raise out_ready -> all tags emerge in order 0..4 with correct sums, none lost or duplicated, payload stable while stalled.
- Random stream of 1000 beats, all ops, random in_valid and out_ready, run with STAGES = 1 and STAGES = 4 -> the scoreboard matches the adder_pkg model exactly.
